// File: rtl/fft_energy_pkg.sv
// Shared types and width helpers for the FFT bin-energy accumulator.
package fft_energy_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FIRST = 3'd1,
    S_ACCUM = 3'd2,
    S_LAST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Exact width of re^2 + im^2 for signed data_w-bit operands.
  function automatic int pwr_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

  function automatic int acc_w(input int data_w, input int avg_log2);
    return pwr_w(data_w) + avg_log2;
  endfunction

endpackage

// File: rtl/fft_energy_accumulator_bin_acc_ram.sv
// Per-bin accumulator storage: simple dual-port RAM, one write port, one registered read port.
module bin_acc_ram #(
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 37
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_energy_accumulator.sv
// Averages per-bin FFT power over 2^AVG_LOG2 frames and thresholds each bin.
// Define FFT_ENERGY_PEAK_EN to track the strongest bin of each window.
module fft_energy_accumulator import fft_energy_pkg::*; #(
  parameter int DATA_W    = 16,
  parameter int NFFT_LOG2 = 8,
  parameter int AVG_LOG2  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 sclr,
  input  logic                 enable,
  input  logic                 dv,
  input  logic [DATA_W-1:0]    xk_re,
  input  logic [DATA_W-1:0]    xk_im,
  input  logic [NFFT_LOG2-1:0] xk_index,
  input  logic [2*DATA_W:0]    threshold,
  output logic                 out_valid,
  output logic [NFFT_LOG2-1:0] out_index,
  output logic [2*DATA_W:0]    out_energy,
  output logic                 detect,
  output logic                 frame_done,
  output logic                 any_detect,
  output logic                 err,
  output logic                 busy,
  output logic [NFFT_LOG2-1:0] peak_index,
  output logic [2*DATA_W:0]    peak_energy
);

  localparam int PW     = pwr_w(DATA_W);
  localparam int ACC_W  = acc_w(DATA_W, AVG_LOG2);
  localparam int STAGES = 2;

  typedef struct packed {
    state_t               state;
    logic                 drain;
    logic [AVG_LOG2-1:0]  frame_cnt;
    logic [NFFT_LOG2-1:0] exp_idx;
    logic [STAGES:0]      vld_pipe;
    logic                 win_det;
    logic                 err;
    logic                 out_valid;
    logic [NFFT_LOG2-1:0] out_index;
    logic [PW-1:0]        out_energy;
    logic                 detect;
    logic                 frame_done;
    logic                 any_detect;
`ifdef FFT_ENERGY_PEAK_EN
    logic [NFFT_LOG2-1:0] pk_idx_run;
    logic [PW-1:0]        pk_e_run;
    logic [NFFT_LOG2-1:0] peak_index;
    logic [PW-1:0]        peak_energy;
`endif
  } ctl_t;

  ctl_t c;

  state_t                   op1, op2, op3, take_op;
  logic [NFFT_LOG2-1:0]     idx1, idx2, idx3;
  logic signed [DATA_W-1:0] re1, im1;
  logic signed [2*DATA_W-1:0] re_sq, im_sq;
  logic [PW-1:0]            p_nx, p2, avg3;
  logic [ACC_W-1:0]         rd_data, rd2, sum2;
  logic [AVG_LOG2-1:0]      cnt_nx;
  logic in_win, start, take, bad, last_bin, wr_en, res_v, res_det, fin;

  assign in_win   = (c.state == S_FIRST || c.state == S_ACCUM || c.state == S_LAST) && !c.drain;
  assign start    = (c.state == S_IDLE) && enable && dv && (xk_index == '0);
  assign take     = start || (in_win && dv && (xk_index == c.exp_idx));
  assign bad      = in_win && dv && (xk_index != c.exp_idx);
  assign take_op  = start ? S_FIRST : c.state;
  assign last_bin = (xk_index == '1);
  assign cnt_nx   = c.frame_cnt + AVG_LOG2'(1);

  assign re_sq = (2*DATA_W)'(re1) * (2*DATA_W)'(re1);
  assign im_sq = (2*DATA_W)'(im1) * (2*DATA_W)'(im1);
  assign p_nx  = {1'b0, re_sq} + {1'b0, im_sq};
  // The first frame overwrites whatever the RAM held, so no clear pass is needed.
  assign sum2  = (op2 == S_FIRST) ? ACC_W'(p2) : rd2 + ACC_W'(p2);
  assign wr_en = c.vld_pipe[1] && (op2 != S_LAST);

  assign res_v   = c.vld_pipe[2] && (op3 == S_LAST);
  assign res_det = avg3 > threshold;
  assign fin     = c.out_valid && (c.out_index == '1);

  // Datapath carries no reset; vld_pipe qualifies every stage.
  always_ff @(posedge clock) begin
    re1  <= $signed(xk_re);
    im1  <= $signed(xk_im);
    idx1 <= xk_index;
    op1  <= take_op;
    op2  <= op1;
    idx2 <= idx1;
    p2   <= p_nx;
    rd2  <= rd_data;
    op3  <= op2;
    idx3 <= idx2;
    avg3 <= sum2[ACC_W-1:AVG_LOG2];
  end

  bin_acc_ram #(.ADDR_W(NFFT_LOG2), .WIDTH(ACC_W)) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (idx2),
    .wr_data (sum2),
    .rd_addr (xk_index),
    .rd_data (rd_data)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      c <= '0;
    end else if (sclr) begin
      c <= '0;
    end else begin
      c.frame_done <= 1'b0;
      c.out_valid  <= res_v;
      c.detect     <= res_v && res_det;
      c.vld_pipe   <= {c.vld_pipe[STAGES-1:0], take};
      if (res_v) begin
        c.out_index  <= idx3;
        c.out_energy <= avg3;
        c.win_det    <= c.win_det | res_det;
`ifdef FFT_ENERGY_PEAK_EN
        // Strict compare over ascending bins keeps the lowest index on ties.
        if (idx3 == '0 || avg3 > c.pk_e_run) begin
          c.pk_idx_run <= idx3;
          c.pk_e_run   <= avg3;
        end
`endif
      end
      case (c.state)
        S_IDLE: if (start) begin
          c.state     <= S_FIRST;
          c.exp_idx   <= NFFT_LOG2'(1);
          c.frame_cnt <= '0;
          c.win_det   <= 1'b0;
        end
        S_FIRST, S_ACCUM, S_LAST: begin
          if (c.drain) begin
            if (fin) begin
              c.state      <= S_DONE;
              c.frame_done <= 1'b1;
              c.any_detect <= c.win_det;
`ifdef FFT_ENERGY_PEAK_EN
              c.peak_index  <= c.pk_idx_run;
              c.peak_energy <= c.pk_e_run;
`endif
            end
          end else if (bad) begin
            c.err       <= 1'b1;
            c.state     <= S_IDLE;
            c.vld_pipe  <= '0;
            c.out_valid <= 1'b0;
            c.detect    <= 1'b0;
          end else if (take) begin
            c.exp_idx <= c.exp_idx + NFFT_LOG2'(1);
            if (last_bin) begin
              if (c.state == S_LAST) begin
                c.drain <= 1'b1;
              end else begin
                c.frame_cnt <= cnt_nx;
                c.state     <= (cnt_nx == '1) ? S_LAST : S_ACCUM;
              end
            end
          end
        end
        S_DONE: begin
          c.state <= S_IDLE;
          c.drain <= 1'b0;
        end
        default: c.state <= S_IDLE;
      endcase
    end
  end

  assign out_valid  = c.out_valid;
  assign out_index  = c.out_index;
  assign out_energy = c.out_energy;
  assign detect     = c.detect;
  assign frame_done = c.frame_done;
  assign any_detect = c.any_detect;
  assign err        = c.err;
  assign busy       = (c.state != S_IDLE);
`ifdef FFT_ENERGY_PEAK_EN
  assign peak_index  = c.peak_index;
  assign peak_energy = c.peak_energy;
`else
  assign peak_index  = '0;
  assign peak_energy = '0;
`endif

endmodule

// File: tb/tb_fft_energy_accumulator.sv
// Scoreboard bench: a window-level power model queues expected bin results,
// a negedge monitor pops them as the accumulator reports.
module tb_fft_energy_accumulator;
  localparam int DW = 16, NL = 3, AL = 2, N = 8, F = 4;

  logic clock = 1'b0, reset = 1'b1, sclr = 1'b0, enable = 1'b1, dv = 1'b0;
  logic [DW-1:0]   xk_re = '0, xk_im = '0;
  logic [NL-1:0]   xk_index = '0;
  logic [2*DW:0]   threshold = '0;
  logic            out_valid, detect, frame_done, any_detect, err, busy;
  logic [NL-1:0]   out_index, peak_index;
  logic [2*DW:0]   out_energy, peak_energy;

  always #5 clock = ~clock;

  fft_energy_accumulator #(.DATA_W(DW), .NFFT_LOG2(NL), .AVG_LOG2(AL)) dut (
    .clock(clock), .reset(reset), .sclr(sclr), .enable(enable), .dv(dv),
    .xk_re(xk_re), .xk_im(xk_im), .xk_index(xk_index), .threshold(threshold),
    .out_valid(out_valid), .out_index(out_index), .out_energy(out_energy),
    .detect(detect), .frame_done(frame_done), .any_detect(any_detect),
    .err(err), .busy(busy), .peak_index(peak_index), .peak_energy(peak_energy)
  );

  typedef struct { int idx; longint e; bit det; } bin_t;
  typedef struct { bit any; int pidx; longint pe; } fd_t;
  bin_t bin_q[$];
  fd_t  fd_q[$];
  int checks = 0, errors = 0;
  logic signed [DW-1:0] re_a [F][N];
  logic signed [DW-1:0] im_a [F][N];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (out_valid) begin
      if (bin_q.size() == 0) chk("unexpected_out_valid", longint'(out_valid), 0);
      else begin
        bin_t b;
        b = bin_q.pop_front();
        chk("out_index", longint'(out_index), b.idx);
        chk("out_energy", longint'(out_energy), b.e);
        chk("detect", longint'(detect), longint'(b.det));
      end
    end else if (detect) chk("detect_unqualified", longint'(detect), 0);
    if (frame_done) begin
      if (fd_q.size() == 0) chk("unexpected_frame_done", longint'(frame_done), 0);
      else begin
        fd_t d;
        d = fd_q.pop_front();
        chk("any_detect", longint'(any_detect), longint'(d.any));
        chk("peak_index", longint'(peak_index), d.pidx);
        chk("peak_energy", longint'(peak_energy), d.pe);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    dv = 1'b0;
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic send(input int idx, input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    dv = 1'b1; xk_index = idx[NL-1:0]; xk_re = re; xk_im = im;
    @(posedge clock); #1;
    dv = 1'b0;
  endtask

  task automatic fill_const(input logic signed [DW-1:0] re, input logic signed [DW-1:0] im);
    for (int f = 0; f < F; f++)
      for (int b = 0; b < N; b++) begin re_a[f][b] = re; im_a[f][b] = im; end
  endtask

  task automatic fill_rand();
    for (int f = 0; f < F; f++)
      for (int b = 0; b < N; b++) begin re_a[f][b] = 16'($urandom); im_a[f][b] = 16'($urandom); end
  endtask

  // Reference: mean of re^2+im^2 over the F frames, floored.
  task automatic push_expect(input logic [2*DW:0] thr);
    fd_t d;
    d.any = 1'b0; d.pidx = 0; d.pe = -1;
    for (int b = 0; b < N; b++) begin
      bin_t r;
      longint s;
      s = 0;
      for (int f = 0; f < F; f++)
        s += longint'(re_a[f][b]) * longint'(re_a[f][b]) + longint'(im_a[f][b]) * longint'(im_a[f][b]);
      r.idx = b; r.e = s / F; r.det = (r.e > longint'(thr));
      bin_q.push_back(r);
      d.any |= r.det;
      if (r.e > d.pe) begin d.pe = r.e; d.pidx = b; end
    end
`ifndef FFT_ENERGY_PEAK_EN
    d.pidx = 0; d.pe = 0;
`endif
    fd_q.push_back(d);
  endtask

  task automatic send_frames(input int nfull, input int nbins);
    for (int f = 0; f < nfull; f++)
      for (int b = 0; b < N; b++) send(b, re_a[f][b], im_a[f][b]);
    for (int b = 0; b < nbins; b++) send(b, re_a[nfull][b], im_a[nfull][b]);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (bin_q.size() == 0 && fd_q.size() == 0) break;
      @(posedge clock); #1;
    end
    chk("drain_pending", longint'(bin_q.size() + fd_q.size()), 0);
    bin_q.delete(); fd_q.delete();
    idle(2);
    chk("busy_after_window", longint'(busy), 0);
  endtask

  task automatic send_window(input logic [2*DW:0] thr, input bit gaps, input bit pre);
    threshold = thr;
    push_expect(thr);
    if (pre) for (int i = 5; i < N; i++) send(i, 16'sd1234, 16'sd1);
    for (int f = 0; f < F; f++)
      for (int b = 0; b < N; b++) begin
        if (gaps) idle($urandom_range(0, 2));
        send(b, re_a[f][b], im_a[f][b]);
      end
    wait_drain();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, longint'(out_valid), 0);
    chk({tag, "_out_index"}, longint'(out_index), 0);
    chk({tag, "_out_energy"}, longint'(out_energy), 0);
    chk({tag, "_detect"}, longint'(detect), 0);
    chk({tag, "_frame_done"}, longint'(frame_done), 0);
    chk({tag, "_any_detect"}, longint'(any_detect), 0);
    chk({tag, "_err"}, longint'(err), 0);
    chk({tag, "_busy"}, longint'(busy), 0);
    chk({tag, "_peak_index"}, longint'(peak_index), 0);
    chk({tag, "_peak_energy"}, longint'(peak_energy), 0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    @(negedge clock); chk_zero("in_reset");
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock); chk_zero("post_reset");
    @(posedge clock); #1;

    fill_const(16'sd3, 16'sd4);
    send_window(33'd24, 1'b0, 1'b1);
    send_window(33'd25, 1'b0, 1'b0);

    fill_const(-16'sd32768, -16'sd32768);
    send_window(33'h0_8000_0000, 1'b1, 1'b0);
    send_window(33'h0_7FFF_FFFF, 1'b0, 1'b0);

    // Index skip in frame 2 discards the window; the next window must still work.
    fill_rand();
    threshold = 33'd1000;
    send_frames(1, 4);
    send(5, re_a[1][5], im_a[1][5]);
    idle(4);
    @(negedge clock);
    chk("err_after_skip", longint'(err), 1);
    chk("busy_after_skip", longint'(busy), 0);
    fill_rand();
    send_window(33'h0_4000_0000, 1'b0, 1'b1);
    chk("err_sticky", longint'(err), 1);

    // Synchronous clear mid-window.
    send_frames(0, 5);
    sclr = 1'b1; @(posedge clock); #1; sclr = 1'b0;
    @(negedge clock); chk_zero("sclr");
    @(posedge clock); #1;

    // Asynchronous reset mid frame 3 with large data left in RAM.
    fill_const(16'sd32767, -16'sd32768);
    send_frames(2, 4);
    #2 reset = 1'b1;
    @(negedge clock); chk_zero("reset_abort");
    @(posedge clock); #1; reset = 1'b0;
    fill_const(16'sd7, -16'sd24);
    send_window(33'd624, 1'b1, 1'b0);

    // Single strong bin.
    fill_const(16'sd0, 16'sd0);
    for (int f = 0; f < F; f++) re_a[f][5] = 16'sd100;
    send_window(33'd0, 1'b0, 1'b0);

    for (int w = 0; w < 5; w++) begin
      fill_rand();
      send_window(33'($urandom_range(0, 32'h6000_0000)), 1'b1, w[0]);
    end

    // Small signed values with a threshold landing inside the range.
    for (int f = 0; f < F; f++)
      for (int b = 0; b < N; b++) begin
        re_a[f][b] = 16'($signed($urandom_range(0, 40)) - 20);
        im_a[f][b] = 16'($signed($urandom_range(0, 40)) - 20);
      end
    send_window(33'd300, 1'b1, 1'b0);

    // Disabled: a full frame must be ignored.
    enable = 1'b0;
    send_frames(1, 0);
    idle(5);
    @(negedge clock);
    chk("busy_disabled", longint'(busy), 0);
    enable = 1'b1;

    @(negedge clock);
    chk("queues_empty", longint'(bin_q.size() + fd_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
